// File: rtl/lsu_mem_if.sv
// Load/store unit bridging execute-stage requests to a byte-enabled data SRAM.
// One request in flight; registered, extended load data on the response side.
module lsu_mem_if #(
  parameter int SIZE = 4096
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [2:0]              req_funct3_i,
  input  logic [31:0]             req_addr_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [31:0]             resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    mem_we_o,
  output logic                    mem_re_o,
  output logic [3:0]              mem_ble_o,
  output logic [31:0]             mem_d_o,
  output logic [$clog2(SIZE)-1:0] mem_add_o,
  input  logic [31:0]             mem_d_i
);

  localparam int AW = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic            bad_f3;
  logic            mis;
  logic            oor;
  logic            err_c;
  logic            acc;
  logic [3:0]      ble;
  logic [31:0]     wd;
  logic [31:0]     sh;
  logic [31:0]     ext;

  // Illegal: reserved encodings, or unsigned variants used for a store
  assign bad_f3 = (req_funct3_i == 3'b011)
                | (req_funct3_i[2:1] == 2'b11)
                | (req_funct3_i[2] & req_we_i);
  assign mis = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0])
             | ((req_funct3_i[1:0] == 2'b10) & (|req_addr_i[1:0]));
  assign oor   = |req_addr_i[31:AW];
  assign err_c = bad_f3 | mis | oor;

  assign sh = mem_d_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    ble = 4'b0000;
    wd  = 32'h0;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: begin
        ble = 4'b0001 << addr_q[1:0];
        wd  = {4{wdata_q[7:0]}};
      end
      f3_q[1:0] == 2'b01: begin
        ble = 4'b0011 << addr_q[1:0];
        wd  = {2{wdata_q[15:0]}};
      end
      default: begin
        ble = 4'b1111;
        wd  = wdata_q;
      end
    endcase
  end

  always_comb begin
    ext = 32'h0;
    unique case (1'b1)
      f3_q == 3'b000: ext = {{24{sh[7]}}, sh[7:0]};
      f3_q == 3'b001: ext = {{16{sh[15]}}, sh[15:0]};
      f3_q == 3'b100: ext = {24'h0, sh[7:0]};
      f3_q == 3'b101: ext = {16'h0, sh[15:0]};
      default:        ext = sh;
    endcase
  end

  // SRAM port is live only in ACCESS so async reset kills a pending write
  assign acc          = (state == ACCESS);
  assign mem_we_o     = acc & we_q;
  assign mem_re_o     = acc & ~we_q;
  assign mem_ble_o    = acc ? ble : 4'b0000;
  assign mem_d_o      = acc ? wd : 32'h0;
  assign mem_add_o    = acc ? {2'b00, addr_q[AW-1:2]} : '0;
  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = (state == RESP);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_rdata_o <= 32'h0;
      resp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i[AW-1:0];
            wdata_q <= req_wdata_i;
            if (err_c) begin
              resp_err_o <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) resp_rdata_o <= ext;
          state <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_rdata_o <= 32'h0;
            resp_err_o   <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a behavioural byte-lane SRAM.
// Each test task drives one scenario and checks the response inline.
module tb_lsu_mem_if;

  localparam int SIZE = 4096;
  localparam int AW   = $clog2(SIZE);

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic          mem_re;
  logic [3:0]    mem_ble;
  logic [31:0]   mem_d;
  logic [AW-1:0] mem_add;
  logic [31:0]   mem_q;

  int passed = 0;
  int total  = 0;
  int we_count = 0;

  logic [31:0] sram [SIZE/4];

  lsu_mem_if #(.SIZE(SIZE)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_we_o     (mem_we),
    .mem_re_o     (mem_re),
    .mem_ble_o    (mem_ble),
    .mem_d_o      (mem_d),
    .mem_add_o    (mem_add),
    .mem_d_i      (mem_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      we_count++;
      for (int i = 0; i < 4; i++)
        if (mem_ble[i]) sram[mem_add[AW-3:0]][8*i+:8] <= mem_d[8*i+:8];
    end
  end

  always_comb begin
    mem_q = 32'h0;
    if (mem_re)
      mem_q = sram[mem_add[AW-3:0]] &
              {{8{mem_ble[3]}}, {8{mem_ble[2]}}, {8{mem_ble[1]}}, {8{mem_ble[0]}}};
  end

  task automatic run(input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [3:0] ble, output logic [31:0] md,
                     output logic [AW-1:0] madd, output logic mwe,
                     output logic mre, output int lat,
                     output logic [31:0] rdata, output logic err);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ble  = mem_ble;
    md   = mem_d;
    madd = mem_add;
    mwe  = mem_we;
    mre  = mem_re;
    lat  = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_re,
         mem_ble, mem_d, mem_add} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
         4'h0, 32'h0, {AW{1'b0}}})
      $display("FAIL reset_outputs ready=%b valid=%b rdata=%h err=%b we=%b re=%b ble=%b required ready=1 others 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_re, mem_ble);
    else passed++;
    #11;
    rstn = 1'b1;
  endtask

  task automatic test_store_load();
    logic [3:0] ble; logic [31:0] md; logic [AW-1:0] ma;
    logic mwe, mre, err; int lat; logic [31:0] rd;
    run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ble, md, ma, mwe, mre, lat, rd, err);
    total++;
    if ({ble, mwe, mre, md, ma} !== {4'b1111, 1'b1, 1'b0, 32'hDEADBEEF, 12'd4})
      $display("FAIL sw_access ble=%b we=%b re=%b d=%h add=%h required 1111 1 0 deadbeef 4",
               ble, mwe, mre, md, ma);
    else passed++;
    total++;
    if ({lat, err, rd} !== {32'd2, 1'b0, 32'h0})
      $display("FAIL sw_resp lat=%0d err=%b rdata=%h required 2 0 0", lat, err, rd);
    else passed++;
    run(1'b0, 3'b010, 32'h10, 32'h0, ble, md, ma, mwe, mre, lat, rd, err);
    total++;
    if ({ble, mwe, mre} !== {4'b1111, 1'b0, 1'b1})
      $display("FAIL lw_access ble=%b we=%b re=%b required 1111 0 1", ble, mwe, mre);
    else passed++;
    total++;
    if ({lat, err, rd} !== {32'd2, 1'b0, 32'hDEADBEEF})
      $display("FAIL lw_resp lat=%0d err=%b rdata=%h required 2 0 deadbeef", lat, err, rd);
    else passed++;
  endtask

  task automatic test_byte_store();
    logic [3:0] ble; logic [31:0] md; logic [AW-1:0] ma;
    logic mwe, mre, err; int lat; logic [31:0] rd;
    run(1'b1, 3'b010, 32'h10, 32'h11223344, ble, md, ma, mwe, mre, lat, rd, err);
    run(1'b1, 3'b000, 32'h13, 32'h000000A5, ble, md, ma, mwe, mre, lat, rd, err);
    total++;
    if ({ble, md, mwe} !== {4'b1000, 32'hA5A5A5A5, 1'b1})
      $display("FAIL sb_lanes ble=%b d=%h we=%b required 1000 a5a5a5a5 1", ble, md, mwe);
    else passed++;
    run(1'b1, 3'b001, 32'h16, 32'h0000BEEF, ble, md, ma, mwe, mre, lat, rd, err);
    total++;
    if ({ble, md} !== {4'b1100, 32'hBEEFBEEF})
      $display("FAIL sh_lanes ble=%b d=%h required 1100 beefbeef", ble, md);
    else passed++;
    run(1'b0, 3'b010, 32'h10, 32'h0, ble, md, ma, mwe, mre, lat, rd, err);
    total++;
    if (rd !== 32'hA5223344)
      $display("FAIL sb_readback rdata=%h required a5223344", rd);
    else passed++;
  endtask

  task automatic test_loads();
    logic [3:0] ble; logic [31:0] md; logic [AW-1:0] ma;
    logic mwe, mre, err; int lat; logic [31:0] rd;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] exs [4] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFA522, 32'h0000A522};
    logic [3:0]  bls [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      run(1'b0, f3s[i], ads[i], 32'h0, ble, md, ma, mwe, mre, lat, rd, err);
      total++;
      if ({rd, err, ble, mre} !== {exs[i], 1'b0, bls[i], 1'b1})
        $display("FAIL load_ext f3=%b rdata=%h err=%b ble=%b re=%b required %h 0 %b 1",
                 f3s[i], rd, err, ble, mre, exs[i], bls[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    logic [3:0] ble; logic [31:0] md; logic [AW-1:0] ma;
    logic mwe, mre, err; int lat; logic [31:0] rd;
    int wc0;
    logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ads [5] = '{32'h11, 32'h03, SIZE, 32'h10, 32'h10};
    wc0 = we_count;
    for (int i = 0; i < 5; i++) begin
      run(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, ble, md, ma, mwe, mre, lat, rd, err);
      total++;
      if ({err, rd, lat, mwe, mre} !== {1'b1, 32'h0, 32'd1, 1'b0, 1'b0})
        $display("FAIL err_resp case=%0d err=%b rdata=%h lat=%0d we=%b re=%b required 1 0 1 0 0",
                 i, err, rd, lat, mwe, mre);
      else passed++;
    end
    total++;
    if (we_count !== wc0)
      $display("FAIL err_no_write pulses=%0d required %0d", we_count, wc0);
    else passed++;
    run(1'b0, 3'b010, 32'h10, 32'h0, ble, md, ma, mwe, mre, lat, rd, err);
    total++;
    if (rd !== 32'hA5223344)
      $display("FAIL err_mem_intact rdata=%h required a5223344", rd);
    else passed++;
  endtask

  task automatic test_hold();
    int wc0;
    wc0 = we_count;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h55555555;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({resp_valid, resp_rdata, resp_err, req_ready} !== {1'b1, 32'hA5223344, 1'b0, 1'b0})
        $display("FAIL hold cycle=%0d valid=%b rdata=%h err=%b ready=%b required 1 a5223344 0 0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      else passed++;
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    total++;
    if ({resp_valid, resp_rdata, resp_err, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b1})
      $display("FAIL hold_release valid=%b rdata=%h err=%b ready=%b required 0 0 0 1",
               resp_valid, resp_rdata, resp_err, req_ready);
    else passed++;
    total++;
    if (we_count !== wc0)
      $display("FAIL hold_ignored_req pulses=%0d required %0d", we_count, wc0);
    else passed++;
  endtask

  task automatic test_reset_in_access();
    logic [3:0] ble; logic [31:0] md; logic [AW-1:0] ma;
    logic mwe, mre, err; int lat; logic [31:0] rd;
    run(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, ble, md, ma, mwe, mre, lat, rd, err);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1)
      $display("FAIL rst_pre_access we=%b required 1", mem_we);
    else passed++;
    rstn = 1'b0;
    #1;
    total++;
    if ({mem_we, mem_re, mem_ble, req_ready, resp_valid} !== {1'b0, 1'b0, 4'h0, 1'b1, 1'b0})
      $display("FAIL rst_async we=%b re=%b ble=%b ready=%b valid=%b required 0 0 0000 1 0",
               mem_we, mem_re, mem_ble, req_ready, resp_valid);
    else passed++;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (resp_valid !== 1'b0)
      $display("FAIL rst_no_resp valid=%b required 0", resp_valid);
    else passed++;
    run(1'b0, 3'b010, 32'h20, 32'h0, ble, md, ma, mwe, mre, lat, rd, err);
    total++;
    if ({rd, err} !== {32'hCAFEF00D, 1'b0})
      $display("FAIL rst_store_dropped rdata=%h err=%b required cafef00d 0", rd, err);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < SIZE/4; i++) sram[i] = 32'h0;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_store();
    test_loads();
    test_errors();
    test_hold();
    test_reset_in_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
